vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares the single-port video RAM between the Z80 CPU bus and the CRTC character/attribute fetch in the eg2000 core.
- Sits inside glue, between the CPU memory decoder and the video RAM. The CRTC fetch stream that produces pixel/color is its display-side requester.
- The CRTC has fixed priority. A wait counter guarantees the CPU a slot, and the CPU is stalled through a req/ack handshake.

Parameters:
- AW, 11, video RAM address width (2 KB).
- DW, 8, data width.
- MAX_WAIT, 6, CPU wait cycles after which the CPU wins the next grant over a pending CRTC fetch.

Ports:
- clock  in  1  system clock (clk_sys domain).
- reset  in  1  synchronous, active-high reset.
- crtc_req  in  1  one-cycle fetch strobe from the CRTC.
- crtc_addr  in  AW  fetch address, sampled with crtc_req.
- crtc_data  out  DW  fetched byte, valid when crtc_valid=1.
- crtc_valid  out  1  one-cycle pulse, fetch complete.
- crtc_miss  out  1  one-cycle pulse, an unserved CRTC fetch was overwritten.
- cpu_req  in  1  level, held until cpu_ack.
- cpu_we  in  1  1=write, 0=read; stable while cpu_req=1.
- cpu_addr  in  AW  CPU address.
- cpu_din  in  DW  CPU write data.
- cpu_dout  out  DW  CPU read data, valid when cpu_ack=1.
- cpu_ack  out  1  one-cycle pulse, access complete.
- cpu_wait  out  1  equals cpu_req & ~cpu_ack (drives Z80 WAIT).
- ram_addr  out  AW  registered RAM address.
- ram_we  out  1  registered RAM write enable.
- ram_din  out  DW  registered RAM write data.
- ram_dout  in  DW  RAM read data; synchronous, valid 1 cycle after ram_addr.

Behaviour:
- Reset values:
  - ram_addr, ram_din, crtc_data and cpu_dout are 0.
  - ram_we, crtc_valid, crtc_miss and cpu_ack are 0.
  - crtc_pend=0, wait_cnt=0, state=IDLE.
- Reset mid-operation aborts the access in progress. No ack or valid is issued for it, and ram_we is 0 in the cycle after reset is sampled.
- CRTC pending latch:
  - crtc_req=1 sets crtc_pend and loads the address register.
  - If crtc_pend is already set and not being granted that cycle, the address is overwritten and crtc_miss pulses in the next cycle.
- Effective CRTC request: creq = crtc_pend | crtc_req. A strobe can be granted in the same cycle it arrives.
- FSM states: IDLE, ACC, DATA.
  - IDLE and DATA are grant-decision states. If creq or cpu_req is set, the next state is ACC; otherwise IDLE.
  - ACC is always followed by DATA.
- Grant rule, evaluated in a decision state:
  - if cpu_req & (wait_cnt >= MAX_WAIT), grant the CPU;
  - else if creq, grant the CRTC;
  - else if cpu_req, grant the CPU.
  - A CRTC grant clears crtc_pend. A strobe arriving in the same cycle as a CPU grant stays pending.
- ACC cycle:
  - ram_addr is the granted address.
  - ram_we = cpu_we on a CPU grant; 0 on a CRTC grant.
  - ram_din = cpu_din.
- DATA cycle:
  - ram_we=0; ram_dout is valid.
  - On a CRTC grant, crtc_data <= ram_dout and crtc_valid pulses in the following cycle.
  - On a CPU grant, cpu_dout <= ram_dout on reads (held unchanged on writes) and cpu_ack pulses in the following cycle.
- Latency:
  - Strobe at cycle t in a decision state gives ACC at t+1, DATA at t+2, valid/ack at t+3.
  - Back-to-back grants give one access per 2 cycles.
- CPU handshake:
  - cpu_req must be low in the cycle after cpu_ack.
  - A cpu_req still high in that cycle is a new request.
  - The granted CPU request is not re-granted while in DATA, because the ack is not yet seen.
  - cpu_req dropped before grant is a protocol violation; behaviour is undefined.
- wait_cnt:
  - increments, saturating at MAX_WAIT, each cycle cpu_req=1 and the CPU is not in ACC/DATA for its own grant;
  - clears on CPU grant or when cpu_req=0.
- Simultaneous CPU and CRTC requests with wait_cnt < MAX_WAIT: the CRTC is served first and the CPU in the next slot.
- Address wrap: addresses are used modulo 2^AW, with no bounds checking.

Test Plan:
- CRTC-only read: preload RAM[0x123]=0xA5; crtc_req at t with addr 0x123 → ram_addr=0x123 at t+1; crtc_data=0xA5 with crtc_valid at t+3; cpu_wait=0 throughout.
- CPU write then read: write 0x3C to 0x7FF → ram_we=1 only in ACC, cpu_ack at +3. Read 0x7FF → cpu_dout=0x3C with cpu_ack; cpu_wait high exactly 3 cycles per access.
- Contention: cpu_req and crtc_req in the same cycle → CRTC served first (valid at +3); CPU ack at +5; no miss.
- Starvation guard: crtc_req every 2 cycles continuously with cpu_req held → CPU granted once wait_cnt reaches 6; ack no later than 9 cycles after req. The CRTC strobe arriving during the CPU grant stays pending and is served next, with no crtc_miss.
- Overrun: crtc_req at 0x010 and 0x020 while the CPU holds ACC/DATA → one crtc_miss pulse; only 0x020 is fetched and crtc_valid pulses once.
- Reset during ACC of a CPU write → ram_we=0 next cycle, no cpu_ack, all outputs at reset values; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/vram_arbiter.sv
// Video RAM arbiter: shares the single-port VRAM between the CRTC fetch stream
// (fixed priority) and the Z80 bus, with a wait counter that guarantees the CPU a slot.
module vram_arbiter #(
  parameter int AW       = 11,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 6
) (
  input  logic          clock,
  input  logic          reset,
  // CRTC side
  input  logic          crtc_req,
  input  logic [AW-1:0] crtc_addr,
  output logic [DW-1:0] crtc_data,
  output logic          crtc_valid,
  output logic          crtc_miss,
  // CPU side
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_ack,
  output logic          cpu_wait,
  // RAM side
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  // FSM state for observation
  output logic [1:0]    fsm_state
);

  // Handshakes: crtc_req is a one-cycle strobe; crtc_valid/crtc_miss/cpu_ack are
  // one-cycle pulses; cpu_req is a level held until (and through) the cpu_ack cycle.

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            crtc_pend;
  logic [AW-1:0]   pend_addr;
  logic            owner_cpu;
  logic            owner_we;
  logic [WCW-1:0]  wait_cnt;

  logic            decide;
  logic            cpu_busy;
  logic            cpu_live;
  logic            creq;
  logic            cpu_urgent;
  logic            grant_cpu;
  logic            grant_crtc;
  logic [AW-1:0]   crtc_gaddr;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Grant decode. The CPU request that owns the current access (or is being
  // acked this cycle) must not be granted a second time.
  always_comb begin
    decide     = (state != ACC);
    cpu_busy   = owner_cpu && (state == ACC || state == DATA);
    cpu_live   = cpu_req && !cpu_ack && !cpu_busy;
    creq       = crtc_pend || crtc_req;
    cpu_urgent = cpu_live && (wait_cnt >= WAIT_MAX);
    grant_cpu  = decide && cpu_live && (cpu_urgent || !creq);
    grant_crtc = decide && creq && !cpu_urgent;
    crtc_gaddr = crtc_pend ? pend_addr : crtc_addr;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DATA: state_nx = (grant_cpu || grant_crtc) ? ACC : IDLE;
      ACC:        state_nx = DATA;
      default:    state_nx = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    cpu_wait  = cpu_req && !cpu_ack;
    fsm_state = state;
  end

  // RAM request registers and access ownership
  always_ff @(posedge clock) begin
    if (reset) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_din   <= '0;
      owner_cpu <= 1'b0;
      owner_we  <= 1'b0;
    end else begin
      ram_we <= grant_cpu && cpu_we;
      if (grant_cpu) begin
        ram_addr  <= cpu_addr;
        ram_din   <= cpu_din;
        owner_cpu <= 1'b1;
        owner_we  <= cpu_we;
      end else if (grant_crtc) begin
        ram_addr  <= crtc_gaddr;
        ram_din   <= cpu_din;
        owner_cpu <= 1'b0;
        owner_we  <= 1'b0;
      end
    end
  end

  // Read-data capture in DATA and completion pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      crtc_data  <= '0;
      crtc_valid <= 1'b0;
      cpu_dout   <= '0;
      cpu_ack    <= 1'b0;
    end else begin
      crtc_valid <= (state == DATA) && !owner_cpu;
      cpu_ack    <= (state == DATA) && owner_cpu;
      if (state == DATA && !owner_cpu)
        crtc_data <= ram_dout;
      if (state == DATA && owner_cpu && !owner_we)
        cpu_dout <= ram_dout;
    end
  end

  // CRTC pending latch. When the pending fetch is granted in the same cycle a
  // new strobe arrives, the new strobe becomes the pending one (nothing is lost).
  always_ff @(posedge clock) begin
    if (reset) begin
      crtc_pend <= 1'b0;
      pend_addr <= '0;
      crtc_miss <= 1'b0;
    end else begin
      crtc_miss <= crtc_req && crtc_pend && !grant_crtc;
      if (crtc_req && (crtc_pend || !grant_crtc)) begin
        crtc_pend <= 1'b1;
        pend_addr <= crtc_addr;
      end else if (grant_crtc) begin
        crtc_pend <= 1'b0;
      end
    end
  end

  // CPU starvation counter
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (grant_cpu || !cpu_req) begin
      wait_cnt <= '0;
    end else if (cpu_live && wait_cnt < WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: CRTC fetch, CPU write/read, contention,
// starvation guard, overrun and reset abort, against a synchronous RAM model.
module tb_vram_arbiter;

  localparam int AW = 11;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          crtc_req;
  logic [AW-1:0] crtc_addr;
  logic [DW-1:0] crtc_data;
  logic          crtc_valid;
  logic          crtc_miss;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic [DW-1:0] cpu_dout;
  logic          cpu_ack;
  logic          cpu_wait;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic [1:0]    fsm_state;

  int checks = 0;
  int failures = 0;

  // clock / reset
  always #5 clock = ~clock;

  vram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(6)) dut (
    .clock(clock), .reset(reset),
    .crtc_req(crtc_req), .crtc_addr(crtc_addr), .crtc_data(crtc_data),
    .crtc_valid(crtc_valid), .crtc_miss(crtc_miss),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .fsm_state(fsm_state)
  );

  // synchronous RAM model with a preload port
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clock) begin
    if (pre_we)      mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    cyc();
    pre_we = 1'b0;
  endtask

  // driver: one CPU access, measuring latency, wait cycles and write strobes
  task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output int lat, output int waits, output int wes,
                            output logic [DW-1:0] dout);
    lat = -1; waits = 0; wes = 0; dout = '0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (cpu_wait) waits++;
      if (cpu_ack) begin
        lat = k; dout = cpu_dout;
        break;
      end
      cyc();
      if (ram_we) wes++;
    end
    cyc();
    cpu_req = 1'b0;
  endtask

  // trace driver: CRTC strobes from a mask, optional CPU read held until ack
  logic [AW-1:0] s_addr   [0:31];
  logic          valid_at [0:31];
  logic [DW-1:0] data_at  [0:31];
  logic          miss_at  [0:31];
  logic          ack_at   [0:31];
  logic [AW-1:0] raddr_at [0:31];
  logic [DW-1:0] ack_data;
  int            first_ack, n_valid, n_miss, n_ack;

  task automatic run_trace(input logic [31:0] smask, input logic cpu_on, input int ncyc);
    logic prev_ack;
    prev_ack = 1'b0;
    first_ack = -1; n_valid = 0; n_miss = 0; n_ack = 0; ack_data = '0;
    for (int k = 0; k < ncyc; k++) begin
      crtc_req  = smask[k];
      crtc_addr = s_addr[k];
      if (k == 0) cpu_req = cpu_on;
      else if (prev_ack) cpu_req = 1'b0;
      #1;
      valid_at[k] = crtc_valid; data_at[k] = crtc_data; miss_at[k] = crtc_miss;
      ack_at[k] = cpu_ack; raddr_at[k] = ram_addr;
      if (crtc_valid) n_valid++;
      if (crtc_miss)  n_miss++;
      if (cpu_ack) begin
        n_ack++;
        ack_data = cpu_dout;
        if (first_ack < 0) first_ack = k;
      end
      prev_ack = cpu_ack;
      cyc();
    end
    crtc_req = 1'b0;
    cpu_req  = 1'b0;
  endtask

  int lat, waits, wes, n;
  logic [DW-1:0] dout;

  initial begin
    reset = 1'b1;
    crtc_req = 1'b0; crtc_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    for (int i = 0; i < 32; i++) s_addr[i] = '0;
    preload(11'h123, 8'hA5);
    preload(11'h055, 8'h5A);
    preload(11'h010, 8'h11);
    preload(11'h020, 8'h22);
    cyc();

    // reset values
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_din", ram_din, 0);
    check("rst_crtc_data", crtc_data, 0);
    check("rst_pulses", {crtc_valid, crtc_miss, cpu_ack}, 0);
    check("rst_cpu_dout", cpu_dout, 0);
    check("rst_state", fsm_state, 0);
    reset = 1'b0;
    cyc();

    // CRTC-only read
    crtc_req = 1'b1; crtc_addr = 11'h123;
    #1 check("t1_cpu_wait", cpu_wait, 0);
    cyc();
    crtc_req = 1'b0;
    check("t1_ram_addr", ram_addr, 11'h123);
    check("t1_ram_we", ram_we, 0);
    cyc();
    check("t1_valid_early", crtc_valid, 0);
    cyc();
    check("t1_valid", crtc_valid, 1);
    check("t1_data", crtc_data, 8'hA5);
    cyc();
    check("t1_valid_once", crtc_valid, 0);
    cyc();

    // CPU write then read
    cpu_access(1'b1, 11'h7FF, 8'h3C, lat, waits, wes, dout);
    check("t2_wr_lat", lat, 3);
    check("t2_wr_waits", waits, 3);
    check("t2_wr_we_cycles", wes, 1);
    cyc();
    cpu_access(1'b0, 11'h7FF, 8'h00, lat, waits, wes, dout);
    check("t2_rd_lat", lat, 3);
    check("t2_rd_waits", waits, 3);
    check("t2_rd_we_cycles", wes, 0);
    check("t2_rd_dout", dout, 8'h3C);
    cyc(); cyc();

    // contention: CRTC first, CPU in the next slot
    cpu_we = 1'b0; cpu_addr = 11'h055;
    s_addr[0] = 11'h123;
    run_trace(32'h1, 1'b1, 10);
    check("t3_valid_t3", valid_at[3], 1);
    check("t3_data", data_at[3], 8'hA5);
    check("t3_ack_t5", first_ack, 5);
    check("t3_ack_data", ack_data, 8'h5A);
    check("t3_n_valid", n_valid, 1);
    check("t3_n_miss", n_miss, 0);
    cyc(); cyc();

    // starvation guard: strobes every 2 cycles, CPU held
    for (int i = 0; i < 32; i++) s_addr[i] = 11'h123;
    run_trace(32'h0555, 1'b1, 18);
    check("t4_ack_cycle", first_ack, 9);
    check("t4_n_ack", n_ack, 1);
    check("t4_ack_data", ack_data, 8'h5A);
    check("t4_n_miss", n_miss, 0);
    check("t4_n_valid", n_valid, 6);
    check("t4_valid_pattern",
          {valid_at[3], valid_at[5], valid_at[7], valid_at[11], valid_at[13], valid_at[15]}, 6'h3F);
    cyc(); cyc();

    // overrun while the CPU holds ACC/DATA
    s_addr[6] = 11'h010;
    s_addr[7] = 11'h020;
    run_trace(32'h00D5, 1'b1, 16);
    check("t5_n_miss", n_miss, 1);
    check("t5_miss_t8", miss_at[8], 1);
    check("t5_ack_cycle", first_ack, 9);
    check("t5_fetch_addr", raddr_at[9], 11'h020);
    check("t5_n_valid", n_valid, 4);
    check("t5_valid_t11", valid_at[11], 1);
    check("t5_data", data_at[11], 8'h22);
    cyc(); cyc();

    // reset during ACC of a CPU write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h100; cpu_din = 8'h77;
    cyc();
    check("t6_acc_we", ram_we, 1);
    reset = 1'b1; cpu_req = 1'b0;
    cyc();
    check("t6_ram_we", ram_we, 0);
    check("t6_ram_addr", ram_addr, 0);
    check("t6_ram_din", ram_din, 0);
    check("t6_cpu_dout", cpu_dout, 0);
    check("t6_crtc_data", crtc_data, 0);
    check("t6_pulses", {crtc_valid, crtc_miss, cpu_ack}, 0);
    check("t6_state", fsm_state, 0);
    reset = 1'b0;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (cpu_ack) n++;
    end
    check("t6_no_ack", n, 0);
    cpu_access(1'b0, 11'h7FF, 8'h00, lat, waits, wes, dout);
    check("t6_fresh_lat", lat, 3);
    check("t6_fresh_dout", dout, 8'h3C);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
